reg_file_dump: RTL

- Parametrised successor to the processor's 2-read/1-write register file.
- Generalised in data width and register count, with optional hardwired-zero register and optional write-to-read bypass.
- Adds a handshaked register-dump port, so benches and on-chip debug logic can stream every register value out of the datapath instead of peeking hierarchically.
- Sits in the same place in the datapath: read ports feed the ALU and data memory, the write port is fed by the write-data mux.

---
 rtl/kgprisc_pkg.sv | 13 +
 rtl/reg_file_dump_if.sv | 30 +++
 rtl/regfile_dump_ctrl.sv | 80 ++++++++
 rtl/reg_file_dump.sv | 74 +++++++
 4 files changed

// File: rtl/kgprisc_pkg.sv
// Shared datapath constants and the register-dump state encoding.
package kgprisc_pkg;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    localparam int KG_DATA_W   = 32;
    localparam int KG_NUM_REGS = 32;

endpackage

// File: rtl/reg_file_dump_if.sv
// Register-file bus: two read ports, one write port and the handshaked dump stream.
interface reg_file_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_start, dump_ready,
        input  rd_data1, rd_data2, dump_busy, dump_valid, dump_index, dump_data, dump_done
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_start, dump_ready,
        output rd_data1, rd_data2, dump_busy, dump_valid, dump_index, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks indices 0..NUM_REGS-1, first beat one cycle after start,
// one beat per cycle under constant ready; a stalled beat holds index and data.
module regfile_dump_ctrl
    import kgprisc_pkg::*;
#(
    parameter int DATA_W   = KG_DATA_W,
    parameter int NUM_REGS = KG_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start_i,
    input  logic              dump_ready_i,
    input  logic [DATA_W-1:0] peek_dat_i,
    output logic [ADDR_W-1:0] peek_idx_o,
    output logic              dump_busy_o,
    output logic              dump_valid_o,
    output logic              dump_done_o,
    output logic [ADDR_W-1:0] dump_index_o,
    output logic [DATA_W-1:0] dump_data_o
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q;
    logic              busy_q;
    logic              valid_q;
    logic              done_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;

    // Register the top should look up (post-write) for the beat loaded at the next edge.
    assign peek_idx_o = (state_q == DUMP_SEND) ? idx_q + ADDR_W'(1) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    if (dump_start_i) begin
                        state_q <= DUMP_SEND;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        data_q  <= peek_dat_i;
                    end
                end
                DUMP_SEND: begin
                    if (dump_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DUMP_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= peek_idx_o;
                            data_q <= peek_dat_i;
                        end
                    end
                end
                DUMP_DONE: begin
                    state_q <= DUMP_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= DUMP_IDLE;
            endcase
        end
    end

    assign dump_busy_o  = busy_q;
    assign dump_valid_o = valid_q;
    assign dump_done_o  = done_q;
    assign dump_index_o = idx_q;
    assign dump_data_o  = data_q;
endmodule

// File: rtl/reg_file_dump.sv
// 2R/1W register file with optional zero register, write bypass and a dump stream.
// Reads are combinational; writes and dump beats advance on the rising edge.
module reg_file_dump
    import kgprisc_pkg::*;
#(
    parameter int DATA_W   = KG_DATA_W,
    parameter int NUM_REGS = KG_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            clock,
    input logic            reset,
    reg_file_dump_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_ok;
    logic [ADDR_W-1:0] peek_idx;
    logic [DATA_W-1:0] peek_dat;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              hit,
        input logic [DATA_W-1:0] wdat
    );
        if (!in_range(a) || (ZERO_REG != 0 && a == '0)) return '0;
        if (BYPASS != 0 && hit) return wdat;
        return stored;
    endfunction

    assign wr_ok = bus.wr_en && in_range(bus.wr_addr)
                   && !(ZERO_REG != 0 && bus.wr_addr == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.rd_data1 = read_sel(bus.rd_addr1, regs_q[bus.rd_addr1],
                                   wr_ok && bus.wr_addr == bus.rd_addr1, bus.wr_data);
    assign bus.rd_data2 = read_sel(bus.rd_addr2, regs_q[bus.rd_addr2],
                                   wr_ok && bus.wr_addr == bus.rd_addr2, bus.wr_data);

    // Dump beats capture the value the register holds after this edge's write.
    assign peek_dat = !in_range(peek_idx)                 ? '0 :
                      (wr_ok && bus.wr_addr == peek_idx)  ? bus.wr_data :
                                                            regs_q[peek_idx];

    regfile_dump_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .dump_start_i (bus.dump_start),
        .dump_ready_i (bus.dump_ready),
        .peek_dat_i   (peek_dat),
        .peek_idx_o   (peek_idx),
        .dump_busy_o  (bus.dump_busy),
        .dump_valid_o (bus.dump_valid),
        .dump_done_o  (bus.dump_done),
        .dump_index_o (bus.dump_index),
        .dump_data_o  (bus.dump_data)
    );
endmodule
